imm_disp_extract: RTL and testbench

Two-stage pipelined extractor for x86 displacement and immediate fields. It sits between the instruction-length/decode stage and the sign-extension units. It pulls the disp and imm bytes out of a 16-byte little-endian instruction window and extends them to 32 bits using the existing `sext_8_to_32` / `sext_16_to_32` cells. It delivers them to the address-generation and execute operand path with a valid/ready handshake.

---
 rtl/imm_disp_extract_pkg.sv | 39 +++
 rtl/imm_disp_extract_if.sv | 40 ++++
 rtl/imm_disp_extract_field_sel.sv | 28 ++
 rtl/sext_16_to_32.sv | 7 +
 rtl/sext_8_to_32.sv | 7 +
 rtl/imm_disp_extract.sv | 181 ++++++++++++++++++
 tb/tb_imm_disp_extract.sv | 274 +++++++++++++++++++++++++++
 7 files changed

// File: rtl/imm_disp_extract_pkg.sv
// Shared size encoding, payload structs and helpers for the disp/imm extractor.
package immx_pkg;

  typedef logic [1:0] sz_t;

  localparam sz_t SZ_NONE = 2'b00;
  localparam sz_t SZ_8    = 2'b01;
  localparam sz_t SZ_16   = 2'b10;
  localparam sz_t SZ_32   = 2'b11;

  // S1 payload: raw little-endian fields, still unextended.
  typedef struct packed {
    logic [31:0] disp_raw;
    logic [31:0] imm_raw;
    sz_t         disp_sz;
    sz_t         imm_sz;
    logic        imm_sext;
    logic        err;
  } immx_beat_t;

  // S2 payload: extended operands as presented to the consumer.
  typedef struct packed {
    logic [31:0] disp;
    logic [31:0] imm;
    logic        has_disp;
    logic        has_imm;
    logic        err;
  } immx_res_t;

  function automatic logic [2:0] sz_bytes(sz_t sz);
    case (sz)
      SZ_8:    return 3'd1;
      SZ_16:   return 3'd2;
      SZ_32:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/imm_disp_extract_if.sv
// Valid/ready bundle around the extractor: decode side (in_*) and operand side (out_*).
interface imm_disp_extract_if
  import immx_pkg::*;
#(
  parameter int WIN_BYTES = 16,
  parameter int TAG_W     = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIN_BYTES*8-1:0] in_win;
  logic [3:0]             in_disp_off;
  sz_t                    in_disp_sz;
  logic [3:0]             in_imm_off;
  sz_t                    in_imm_sz;
  logic                   in_imm_sext;
  logic [TAG_W-1:0]       in_tag;

  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_disp;
  logic [31:0]            out_imm;
  logic                   out_has_disp;
  logic                   out_has_imm;
  logic                   out_err;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output in_valid, in_win, in_disp_off, in_disp_sz, in_imm_off, in_imm_sz,
           in_imm_sext, in_tag, out_ready,
    input  in_ready, out_valid, out_disp, out_imm, out_has_disp, out_has_imm,
           out_err, out_tag
  );

  modport slave (
    input  in_valid, in_win, in_disp_off, in_disp_sz, in_imm_off, in_imm_sz,
           in_imm_sext, in_tag, out_ready,
    output in_ready, out_valid, out_disp, out_imm, out_has_disp, out_has_imm,
           out_err, out_tag
  );
endinterface

// File: rtl/imm_disp_extract_field_sel.sv
// Pulls one little-endian field out of the instruction window; a field that
// runs past the window end reads as zero and flags err_o.
module immx_field_sel
  import immx_pkg::*;
#(
  parameter int WIN_BYTES = 16
) (
  input  logic [WIN_BYTES*8-1:0] win_i,
  input  logic [3:0]             off_i,
  input  sz_t                    sz_i,
  output logic [31:0]            raw_o,
  output logic                   err_o
);
  logic [2:0] nbytes;
  logic [4:0] end_pos;

  always_comb begin
    nbytes  = sz_bytes(sz_i);
    end_pos = {1'b0, off_i} + {2'b00, nbytes};
    err_o   = (end_pos > 5'(WIN_BYTES));
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    raw_o   = '0;
    for (int i = 0; i < 4; i++) begin
      if (!err_o && (3'(i) < nbytes))
        raw_o[8*i +: 8] = win_i[{off_i + 4'(i), 3'b000} +: 8];
    end
  end
endmodule

// File: rtl/sext_16_to_32.sv
// Sign-extension cell, 16 to 32 bits.
module sext_16_to_32 (
  input  logic [15:0] a_i,
  output logic [31:0] y_o
);
  assign y_o = {{16{a_i[15]}}, a_i};
endmodule

// File: rtl/sext_8_to_32.sv
// Sign-extension cell, 8 to 32 bits.
module sext_8_to_32 (
  input  logic [7:0]  a_i,
  output logic [31:0] y_o
);
  assign y_o = {{24{a_i[7]}}, a_i};
endmodule

// File: rtl/imm_disp_extract.sv
// Two-stage disp/imm extractor: S1 selects raw field bytes, S2 extends them.
// Define IMMX_OBUF_EN for a 4-entry output FIFO with a registered in_ready.
module imm_disp_extract
  import immx_pkg::*;
#(
  parameter int WIN_BYTES = 16,
  parameter int TAG_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  imm_disp_extract_if.slave bus
);
  logic [31:0]      disp_raw, imm_raw;
  logic             disp_err, imm_err;
  logic [31:0]      disp_s8, disp_s16, imm_s8, imm_s16;

  immx_beat_t       s1_d, s1_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_valid_q;
  immx_res_t        s2_d, s2_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_valid_q;

  logic             adv, s1_load, in_ready, accept;
  logic             out_valid;
  immx_res_t        out_res;
  logic [TAG_W-1:0] out_tag;

  immx_field_sel #(.WIN_BYTES(WIN_BYTES)) u_disp_sel (
    .win_i (bus.in_win),
    .off_i (bus.in_disp_off),
    .sz_i  (bus.in_disp_sz),
    .raw_o (disp_raw),
    .err_o (disp_err)
  );

  immx_field_sel #(.WIN_BYTES(WIN_BYTES)) u_imm_sel (
    .win_i (bus.in_win),
    .off_i (bus.in_imm_off),
    .sz_i  (bus.in_imm_sz),
    .raw_o (imm_raw),
    .err_o (imm_err)
  );

  always_comb begin
    s1_d          = '0;
    s1_d.disp_raw = disp_raw;
    s1_d.imm_raw  = imm_raw;
    s1_d.disp_sz  = bus.in_disp_sz;
    s1_d.imm_sz   = bus.in_imm_sz;
    s1_d.imm_sext = bus.in_imm_sext;
    s1_d.err      = disp_err | imm_err;
  end

  sext_8_to_32  u_disp_s8  (.a_i(s1_q.disp_raw[7:0]),  .y_o(disp_s8));
  sext_16_to_32 u_disp_s16 (.a_i(s1_q.disp_raw[15:0]), .y_o(disp_s16));
  sext_8_to_32  u_imm_s8   (.a_i(s1_q.imm_raw[7:0]),   .y_o(imm_s8));
  sext_16_to_32 u_imm_s16  (.a_i(s1_q.imm_raw[15:0]),  .y_o(imm_s16));

  // Displacement is always signed; immediate honours imm_sext.
  always_comb begin
    s2_d          = '0;
    s2_d.has_disp = (s1_q.disp_sz != SZ_NONE);
    s2_d.has_imm  = (s1_q.imm_sz != SZ_NONE);
    s2_d.err      = s1_q.err;
    case (s1_q.disp_sz)
      SZ_8:    s2_d.disp = disp_s8;
      SZ_16:   s2_d.disp = disp_s16;
      SZ_32:   s2_d.disp = s1_q.disp_raw;
      default: s2_d.disp = '0;
    endcase
    case (s1_q.imm_sz)
      SZ_8:    s2_d.imm = s1_q.imm_sext ? imm_s8  : {24'b0, s1_q.imm_raw[7:0]};
      SZ_16:   s2_d.imm = s1_q.imm_sext ? imm_s16 : {16'b0, s1_q.imm_raw[15:0]};
      SZ_32:   s2_d.imm = s1_q.imm_raw;
      default: s2_d.imm = '0;
    endcase
  end

  assign s1_load      = adv | ~s1_valid_q;
  assign accept       = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_tag_q   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_q     <= s1_d;
          s1_tag_q <= bus.in_tag;
        end
      end
      if (adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_q     <= s2_d;
          s2_tag_q <= s1_tag_q;
        end
      end
    end
  end

`ifdef IMMX_OBUF_EN
  localparam int OBUF_DEPTH = 4;

  immx_res_t        fifo_mem [OBUF_DEPTH];
  logic [TAG_W-1:0] fifo_tag [OBUF_DEPTH];
  logic [1:0]       head_q, tail_q;
  logic [2:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;
  logic [2:0]       occupancy;

  // The FIFO absorbs everything, so the pipeline itself never stalls.
  assign adv        = 1'b1;
  assign in_ready   = in_ready_q & ~rst;
  assign push       = s2_valid_q;
  assign pop        = (count_q != 3'd0) & bus.out_ready;
  assign count_d    = count_q + 3'(push) - 3'(pop);
  // Beats already committed somewhere downstream, including the one taken now;
  // granting one more only while this is below the depth keeps the FIFO from overflowing.
  assign occupancy  = 3'(s1_valid_q) + 3'(s2_valid_q) + count_q + 3'(accept);
  assign in_ready_d = occupancy < 3'(OBUF_DEPTH);

  // NOTE: the storage array has no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail_q] <= s2_q;
      fifo_tag[tail_q] <= s2_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      head_q     <= head_q + 2'(pop);
      tail_q     <= tail_q + 2'(push);
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_valid = (count_q != 3'd0);

  always_comb begin
    out_res = '0;
    out_tag = '0;
    if (out_valid) begin
      out_res = fifo_mem[head_q];
      out_tag = fifo_tag[head_q];
    end
  end
`else
  assign adv       = ~s2_valid_q | bus.out_ready;
  assign in_ready  = s1_load & ~rst;
  assign out_valid = s2_valid_q;
  assign out_res   = s2_q;
  assign out_tag   = s2_tag_q;
`endif

  assign bus.out_valid    = out_valid;
  assign bus.out_disp     = out_res.disp;
  assign bus.out_imm      = out_res.imm;
  assign bus.out_has_disp = out_res.has_disp;
  assign bus.out_has_imm  = out_res.has_imm;
  assign bus.out_err      = out_res.err;
  assign bus.out_tag      = out_tag;

endmodule

// File: tb/tb_imm_disp_extract.sv
// Randomized scoreboard bench for imm_disp_extract with directed boundary beats;
// honours IMMX_OBUF_EN for the FIFO latency and fill behaviour.
module tb_imm_disp_extract;
  localparam int TAG_W = 8;
`ifdef IMMX_OBUF_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [31:0] disp;
    logic [31:0] imm;
    logic        has_d;
    logic        has_i;
    logic        err;
    logic [7:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imm_disp_extract_if #(.WIN_BYTES(16), .TAG_W(TAG_W)) bus ();

  imm_disp_extract #(.WIN_BYTES(16), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  exp_t       exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] next_tag    = 8'd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: gather bytes arithmetically, then sign-adjust by subtracting 2^(8n).
  function automatic logic [31:0] pick(input logic [127:0] win, input int off, input int sz,
                                       input bit sx, output bit ovr);
    int     n;
    longint v;
    n   = (sz == 3) ? 4 : sz;
    v   = 0;
    ovr = 1'b0;
    if (off + n > 16) begin
      ovr = 1'b1;
      return 32'h0;
    end
    for (int k = 0; k < n; k++)
      v += longint'(win[(off + k) * 8 +: 8]) << (8 * k);
    if (sx && n > 0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  function automatic exp_t model(input logic [127:0] win, input int doff, input int dsz,
                                 input int ioff, input int isz, input bit sx,
                                 input logic [7:0] tag);
    exp_t e;
    bit   od, oi;
    e.disp  = pick(win, doff, dsz, 1'b1, od);
    e.imm   = pick(win, ioff, isz, sx, oi);
    e.has_d = (dsz != 0);
    e.has_i = (isz != 0);
    e.err   = od | oi;
    e.tag   = tag;
    return e;
  endfunction

  task automatic score();
    exp_t e;
    if (rst) begin
      check("ready_in_reset", bus.in_ready, 0);
      exp_q.delete();
      return;
    end
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", bus.out_valid, 0);
      end else begin
        e = exp_q[0];
        check("out_disp", bus.out_disp, e.disp);
        check("out_imm", bus.out_imm, e.imm);
        check("out_has_disp", bus.out_has_disp, e.has_d);
        check("out_has_imm", bus.out_has_imm, e.has_i);
        check("out_err", bus.out_err, e.err);
        check("out_tag", bus.out_tag, e.tag);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.in_win, int'(bus.in_disp_off), int'(bus.in_disp_sz),
                            int'(bus.in_imm_off), int'(bus.in_imm_sz), bus.in_imm_sext,
                            bus.in_tag));
  endtask

  // Called at a negedge: drive, settle, score, advance to the next negedge.
  task automatic cycle(input logic v, input logic rdy, output logic acc);
    bus.in_valid  = v;
    bus.out_ready = rdy;
    bus.in_tag    = next_tag;
    #1;
    acc = v & bus.in_ready & ~rst;
    score();
    if (acc) next_tag++;
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [127:0] w, input int doff, input int dsz,
                            input int ioff, input int isz, input bit sx);
    bus.in_win      = w;
    bus.in_disp_off = 4'(doff);
    bus.in_disp_sz  = 2'(dsz);
    bus.in_imm_off  = 4'(ioff);
    bus.in_imm_sz   = 2'(isz);
    bus.in_imm_sext = sx;
  endtask

  task automatic rand_fields();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    set_fields(w, $urandom_range(0, 15), $urandom_range(0, 3),
               $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int c = 0; c < budget && exp_q.size() != 0; c++) cycle(1'b0, 1'b1, acc);
    check("drain_empty", exp_q.size(), 0);
  endtask

  logic [127:0] win;
  logic         acc;
  int           lat, n_acc;
  bit           found;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_fields('0, 0, 0, 0, 0, 1'b0);
    bus.in_tag    = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_disp", bus.out_disp, 0);
    check("rst_out_imm", bus.out_imm, 0);
    check("rst_out_has", {bus.out_has_disp, bus.out_has_imm}, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_out_tag", bus.out_tag, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", bus.in_ready, 1);
    @(negedge clk);

    // Window bytes 0x00..0x0F, latency and literal values
    for (int i = 0; i < 16; i++) win[i*8 +: 8] = 8'(i);
    set_fields(win, 2, 1, 4, 3, 1'b0);
    cycle(1'b1, 1'b1, acc);
    check("t1_accept", acc, 1);
    found = 1'b0;
    lat   = 0;
    for (int c = 1; c <= 8 && !found; c++) begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid) begin
        found = 1'b1;
        lat   = c;
        check("t1_disp_lit", bus.out_disp, 32'h0000_0002);
        check("t1_imm_lit", bus.out_imm, 32'h0706_0504);
      end
      score();
      @(negedge clk);
    end
    check("t1_latency", lat, LAT);

    // Signed and unsigned extension, then overrun followed by a clean beat
    win = {$urandom, $urandom, $urandom, $urandom};
    win[5*8 +: 8] = 8'h80;
    win[8*8 +: 8] = 8'hFE;
    win[9*8 +: 8] = 8'hFF;
    set_fields(win, 5, 1, 8, 2, 1'b1);
    cycle(1'b1, 1'b1, acc);
    set_fields(win, 5, 1, 8, 2, 1'b0);
    cycle(1'b1, 1'b1, acc);
    set_fields(win, 0, 0, 14, 3, 1'b1);
    cycle(1'b1, 1'b1, acc);
    set_fields(win, 15, 1, 12, 3, 1'b1);
    cycle(1'b1, 1'b1, acc);
    set_fields(win, 13, 2, 15, 2, 1'b0);
    cycle(1'b1, 1'b1, acc);
    drain(20);

    // Eight tagged beats with out_ready toggling 1,0,0
    next_tag = 8'd1;
    n_acc    = 0;
    for (int c = 0; c < 100 && n_acc < 8; c++) begin
      rand_fields();
      cycle(1'b1, (c % 3) == 0, acc);
      if (acc) n_acc++;
    end
    check("toggle_accepted", n_acc, 8);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) cycle(1'b0, (c % 3) == 0, acc);
    check("toggle_drained", exp_q.size(), 0);

`ifdef IMMX_OBUF_EN
    // Fill the output buffer with the consumer blocked
    n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      rand_fields();
      cycle(1'b1, 1'b0, acc);
      if (acc) n_acc++;
    end
    check("obuf_fill_count", n_acc, 4);
    #1;
    check("obuf_full_ready", bus.in_ready, 0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cycle(1'b0, 1'b1, acc);
      #1;
      if (bus.in_ready) found = 1'b1;
    end
    check("obuf_ready_back", found, 1);
    drain(20);
`endif

    // Reset with two beats in flight
    rand_fields();
    cycle(1'b1, 1'b1, acc);
    rand_fields();
    cycle(1'b1, 1'b1, acc);
    rst = 1'b1;
    cycle(1'b0, 1'b1, acc);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", {bus.out_disp, bus.out_imm}, 0);
    check("midrst_out_flags", {bus.out_has_disp, bus.out_has_imm, bus.out_err}, 0);
    check("midrst_out_tag", bus.out_tag, 0);
    @(negedge clk);
    for (int c = 0; c < 6; c++) cycle(1'b0, 1'b1, acc);

    // Random traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      rand_fields();
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, acc);
    end
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
